// File: rtl/nios_oci_trace_pkg.sv
// Shared types and helpers for the Nios II OCI trace monitor: FSM states,
// the default FIFO entry layout and a saturating counter step.
package nios_oci_trace_pkg;

    localparam int TRACE_DATA_W  = 30;
    localparam int TRACE_CNT_W   = 4;
    localparam int TRACE_ENTRY_W = TRACE_CNT_W + TRACE_DATA_W;
    localparam int SAT_MAX_W     = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } trace_state_t;

    typedef struct packed {
        logic [TRACE_CNT_W-1:0]  count;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

    // Increment v, but stick at the all-ones value of a w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [SAT_MAX_W-1:0] max_v;
        max_v = (w >= SAT_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/nios_oci_trace_fifo.sv
// Single-clock FIFO with a registered head word: a push into an empty FIFO
// is presented on the very next cycle, and the head holds when empty.
module nios_oci_trace_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_next;
    logic [LVL_W-1:0] level_q;
    logic [WIDTH-1:0] head_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = head_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rd_next = rd_ptr_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_next;
            level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
            // When full, the write lands on the slot being popped, so the new
            // head always comes from rd_next, never from the incoming word.
            if (do_pop) begin
                if (level_q > LVL_W'(1)) begin
                    head_q <= mem_q[rd_next];
                end else if (do_push) begin
                    head_q <= push_data_i;
                end
            end else if (empty_o && do_push) begin
                head_q <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/nios_oci_trace_monitor.sv
// Captures OCI data/control trace frames into a FIFO, streams them out over
// valid/ready, keeps frame/drop statistics and sequences end-of-test drain.
module nios_oci_trace_monitor
    import nios_oci_trace_pkg::*;
#(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int STAT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dct_valid,
    input  logic [DATA_W-1:0]      dct_buffer,
    input  logic [CNT_W-1:0]       dct_count,
    input  logic                   test_ending,
    input  logic                   test_has_ended,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CNT_W-1:0]       out_count,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [STAT_W-1:0]      frame_total,
    output logic [STAT_W-1:0]      drop_total,
    output logic                   overflow,
    output logic                   draining,
    output logic                   done
);

    localparam int ENTRY_W = CNT_W + DATA_W;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    // Handshake: a word moves downstream on every rising edge where
    // out_valid and out_ready are both 1; out_data/out_count stay put
    // while out_valid=1 and out_ready=0.
    trace_state_t       state_q, state_d;
    logic [STAT_W-1:0]  frame_total_q, frame_total_d;
    logic [STAT_W-1:0]  drop_total_q, drop_total_d;
    logic               overflow_q, overflow_d;

    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               push_req, push_ok, drop, pop, empty_after_pop;

    assign push_req = dct_valid && (dct_count != '0) && (state_q == RUN);
    assign pop      = out_valid && out_ready;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    nios_oci_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_ok),
        .push_data_i ({dct_count, dct_buffer}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fill_level)
    );

    assign out_valid              = !fifo_empty;
    assign {out_count, out_data}  = fifo_head;

    // Pushes are closed outside RUN, so occupancy after this edge is level - pop.
    assign empty_after_pop = fifo_empty || ((fill_level == LVL_W'(1)) && pop);

    always_comb begin
        state_d       = state_q;
        frame_total_d = frame_total_q;
        drop_total_d  = drop_total_q;
        overflow_d    = overflow_q;
        case (state_q)
            RUN:     if (test_ending) state_d = DRAIN;
            DRAIN:   if (test_has_ended && empty_after_pop) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
        if (push_ok) begin
            frame_total_d = STAT_W'(sat_inc(SAT_MAX_W'(frame_total_q), STAT_W));
        end
        if (drop) begin
            drop_total_d = STAT_W'(sat_inc(SAT_MAX_W'(drop_total_q), STAT_W));
            overflow_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            frame_total_q <= '0;
            drop_total_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_total_q <= frame_total_d;
            drop_total_q  <= drop_total_d;
            overflow_q    <= overflow_d;
        end
    end

    assign frame_total = frame_total_q;
    assign drop_total  = drop_total_q;
    assign overflow    = overflow_q;
    assign draining    = (state_q == DRAIN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_nios_oci_trace_monitor.sv
// Directed bench for nios_oci_trace_monitor: stream, null/backpressure,
// overflow, full push+pop, end-of-test sequencing and reset behaviour.
module tb_nios_oci_trace_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        dct_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [4:0]  fill_level;
    logic [31:0] frame_total;
    logic [31:0] drop_total;
    logic        overflow;
    logic        draining;
    logic        done;

    int vectors = 0;
    int miscompares = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    nios_oci_trace_monitor #(
        .DATA_W (30),
        .CNT_W  (4),
        .DEPTH  (16),
        .STAT_W (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dct_valid      (dct_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count),
        .fill_level     (fill_level),
        .frame_total    (frame_total),
        .drop_total     (drop_total),
        .overflow       (overflow),
        .draining       (draining),
        .done           (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [29:0] d);
        dct_valid  = v;
        dct_count  = c;
        dct_buffer = d;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"},   64'(out_valid),   64'd0);
        check({tag, "_fill_level"},  64'(fill_level),  64'd0);
        check({tag, "_frame_total"}, 64'(frame_total), 64'd0);
        check({tag, "_drop_total"},  64'(drop_total),  64'd0);
        check({tag, "_overflow"},    64'(overflow),    64'd0);
        check({tag, "_draining"},    64'(draining),    64'd0);
        check({tag, "_done"},        64'(done),        64'd0);
        check({tag, "_out_data"},    64'(out_data),    64'd0);
        check({tag, "_out_count"},   64'(out_count),   64'd0);
    endtask

    task automatic check_head(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (exp_q.size() > 0) begin
            check({tag, "_head"}, 64'({out_count, out_data}), 64'(exp_q[0]));
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, 30'd0);
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        out_ready      = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();
        check_reset_state("post_reset");

        // Basic stream with out_ready held high.
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 4'(i), 30'(i));
            tick();
            check("stream_valid", 64'(out_valid),  64'd1);
            check("stream_data",  64'(out_data),   64'(i));
            check("stream_count", 64'(out_count),  64'(i));
            check("stream_fill",  64'(fill_level), 64'd1);
        end
        drive(1'b0, 4'd0, 30'd0);
        tick();
        check("stream_end_valid", 64'(out_valid),   64'd0);
        check("stream_end_fill",  64'(fill_level),  64'd0);
        check("stream_total",     64'(frame_total), 64'd3);

        // Null frame, then one frame held under backpressure.
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 30'h123);
        tick();
        check("null_fill",  64'(fill_level),  64'd0);
        check("null_total", 64'(frame_total), 64'd3);
        drive(1'b1, 4'd5, 30'h3FFFFFFF);
        tick();
        drive(1'b0, 4'd0, 30'd0);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(out_valid),  64'd1);
            check("bp_data",  64'(out_data),   64'h3FFFFFFF);
            check("bp_count", 64'(out_count),  64'd5);
            check("bp_fill",  64'(fill_level), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_drain_fill", 64'(fill_level), 64'd0);
        check("bp_total",      64'(frame_total), 64'd4);

        // Overflow: 20 pushes into 16 slots with no pops.
        out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 4'((i % 15) + 1), 30'(100 + i));
            if (i <= 16) exp_q.push_back({4'((i % 15) + 1), 30'(100 + i)});
            tick();
        end
        drive(1'b0, 4'd0, 30'd0);
        check("ovf_fill",     64'(fill_level),  64'd16);
        check("ovf_drop",     64'(drop_total),  64'd4);
        check("ovf_sticky",   64'(overflow),    64'd1);
        check("ovf_total",    64'(frame_total), 64'd20);
        check("ovf_head",     64'(out_data),    64'd101);

        // Full FIFO, push and pop together: accepted, no drop.
        drive(1'b1, 4'd7, 30'h777);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 4'd0, 30'd0);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({4'd7, 30'h777});
        check("fullpp_drop",  64'(drop_total),  64'd4);
        check("fullpp_fill",  64'(fill_level),  64'd16);
        check("fullpp_total", 64'(frame_total), 64'd21);

        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            check_head("ovf_drain");
            tick();
            void'(exp_q.pop_front());
        end
        check("ovf_drain_valid", 64'(out_valid),  64'd0);
        check("ovf_drain_fill",  64'(fill_level), 64'd0);

        // End sequence: 4 queued, 5th pushed alongside test_ending.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 30'(32'h200 + i));
            exp_q.push_back({4'(i), 30'(32'h200 + i)});
            tick();
        end
        drive(1'b1, 4'd5, 30'h205);
        exp_q.push_back({4'd5, 30'h205});
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check("end_draining", 64'(draining),    64'd1);
        check("end_done",     64'(done),        64'd0);
        check("end_fill",     64'(fill_level),  64'd5);
        check("end_total",    64'(frame_total), 64'd26);
        drive(1'b1, 4'd9, 30'h999);
        tick();
        drive(1'b0, 4'd0, 30'd0);
        check("late_push_fill",  64'(fill_level),  64'd5);
        check("late_push_total", 64'(frame_total), 64'd26);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            check_head("end_drain");
            check("end_drain_done", 64'(done), 64'd0);
            tick();
            void'(exp_q.pop_front());
        end
        check("end_empty_fill",     64'(fill_level), 64'd0);
        check("end_empty_draining", 64'(draining),   64'd1);
        check("end_empty_done",     64'(done),       64'd0);
        test_has_ended = 1'b1;
        tick();
        check("done_rise",     64'(done),     64'd1);
        check("done_draining", 64'(draining), 64'd0);
        drive(1'b1, 4'd3, 30'h333);
        tick();
        drive(1'b0, 4'd0, 30'd0);
        check("done_hold", 64'(done),       64'd1);
        check("done_fill", 64'(fill_level), 64'd0);

        reset = 1'b1;
        test_has_ended = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_reset_state("reset_after_done");

        // test_ending and test_has_ended together in RUN with an empty FIFO.
        test_ending = 1'b1;
        test_has_ended = 1'b1;
        tick();
        test_ending = 1'b0;
        check("both_draining", 64'(draining), 64'd1);
        check("both_done0",    64'(done),     64'd0);
        tick();
        check("both_done1",    64'(done),     64'd1);
        check("both_drain0",   64'(draining), 64'd0);
        test_has_ended = 1'b0;

        // Reset in DRAIN with 3 entries queued.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 4'(i), 30'(32'h300 + i));
            tick();
        end
        drive(1'b0, 4'd0, 30'd0);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check("mid_draining", 64'(draining),  64'd1);
        check("mid_fill",     64'(fill_level), 64'd3);
        check("mid_valid",    64'(out_valid),  64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("mid_reset");
        drive(1'b1, 4'd1, 30'h42);
        tick();
        drive(1'b0, 4'd0, 30'd0);
        check("rerun_fill",  64'(fill_level),  64'd1);
        check("rerun_total", 64'(frame_total), 64'd1);
        check("rerun_data",  64'(out_data),    64'h42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
